wave_capture: RTL and testbench

- Receive-side counterpart to the waveform generator output path: samples an 8-bit waveform bus arriving from a PMOD ADC/loopback into a circular BRAM-style buffer.
- Triggers on a rising crossing of a programmable level, captures a programmable number of post-trigger samples, then freezes.
- Exposes the frozen record through a 1-cycle-latency read port, ordered oldest-first, for checking the generated sine/square/triangle/saw output.

---
 rtl/wave_capture_if.sv | 13 +
 rtl/wave_capture.sv | 126 ++++++++++++
 tb/tb_wave_capture.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_if.sv
// Readout port of the capture buffer: request index in, sample and valid strobe back.
interface wave_capture_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (output rd_en, rd_addr, input rd_data, rd_valid);
    modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/wave_capture.sv
// Triggered waveform capture into a circular buffer; frozen record is read back
// oldest-first through a 1-cycle-latency port.
module wave_capture #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wave_in,
    input  logic [DIV_W-1:0]  div,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [ADDR_W-1:0] post_count,
    input  logic              arm,
    input  logic              abort,
    output logic              armed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_index,
    wave_capture_if.slave     rd
);
    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_l, div_cnt;
    logic [DATA_W-1:0] trig_l, prev;
    logic [ADDR_W-1:0] post_l, post_rem, wr_ptr, fill_cnt;
    logic              prev_valid;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              active_c, strobe_c, trig_c, arm_c, rd_ok_c;

    assign active_c = (state == ARMED) || (state == POST);
    assign strobe_c = active_c && (div_cnt == div_l);
    assign arm_c    = arm && !abort && ((state == IDLE) || (state == DONE));
    assign rd_ok_c  = (state == DONE) && rd.rd_en;
    // trig_index doubles as the pre-fill requirement (DEPTH-1-post_l)
    assign trig_c   = (state == ARMED) && strobe_c && prev_valid &&
                      (prev < trig_l) && (wave_in >= trig_l) && (fill_cnt >= trig_index);

    // Next-state logic; abort overrides everything else
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (arm) state_next = ARMED;
            ARMED:   if (trig_c) state_next = (post_l == '0) ? DONE : POST;
            POST:    if (strobe_c && (post_rem == ADDR_W'(1))) state_next = DONE;
            DONE:    if (arm) state_next = ARMED;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // State register with status flags registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            armed <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            armed <= (state_next == ARMED);
            busy  <= (state_next == ARMED) || (state_next == POST);
            done  <= (state_next == DONE);
        end
    end

    // Capture control: configuration latch, strobe divider, pointers and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_l      <= '0;
            trig_l     <= '0;
            post_l     <= '0;
            trig_index <= '0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            div_cnt    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            post_rem   <= '0;
        end else if (arm_c) begin
            div_l      <= div;
            trig_l     <= trig_level;
            // post_count is ADDR_W wide, so it cannot exceed DEPTH-1
            post_l     <= post_count;
            trig_index <= LAST - post_count;
            fill_cnt   <= '0;
            prev_valid <= 1'b0;
            div_cnt    <= '0;
        end else if (strobe_c) begin
            div_cnt    <= '0;
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            prev       <= wave_in;
            prev_valid <= 1'b1;
            if ((state == ARMED) && (fill_cnt != LAST)) fill_cnt <= fill_cnt + ADDR_W'(1);
            if (trig_c) post_rem <= post_l;
            else if (state == POST) post_rem <= post_rem - ADDR_W'(1);
        end else if (active_c) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Sample storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (strobe_c) mem[wr_ptr] <= wave_in;
    end

    // Readout: wr_ptr points at the oldest sample once frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok_c;
            if (rd_ok_c) rd_data <= mem[ADDR_W'(wr_ptr + rd.rd_addr)];
        end
    end

    assign rd.rd_data  = rd_data;
    assign rd.rd_valid = rd_valid;
endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture with a 16-deep buffer.
module tb_wave_capture;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] wave_in;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] trig_level;
    logic [ADDR_W-1:0] post_count;
    logic              arm, abort;
    logic              armed, busy, done;
    logic [ADDR_W-1:0] trig_index;

    int n_asserts = 0;
    int n_fail    = 0;

    logic       ramp_on;
    logic [7:0] ramp_val;
    int         hold, hold_cnt;

    wave_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rd_if ();

    wave_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wave_in    (wave_in),
        .div        (div),
        .trig_level (trig_level),
        .post_count (post_count),
        .arm        (arm),
        .abort      (abort),
        .armed      (armed),
        .busy       (busy),
        .done       (done),
        .trig_index (trig_index),
        .rd         (rd_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are then sampled 1 ns after the edge and the ramp advances
    task automatic step();
        @(posedge clk);
        #1;
        if (ramp_on) begin
            hold_cnt++;
            if (hold_cnt >= hold) begin
                hold_cnt = 0;
                ramp_val = ramp_val + 8'h10;
            end
            wave_in = ramp_val;
        end
    endtask

    task automatic feed(input logic [7:0] v);
        wave_in = v;
        step();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic read_chk(input string tag, input int idx, input logic [7:0] exp);
        rd_if.rd_en   = 1'b1;
        rd_if.rd_addr = ADDR_W'(idx);
        step();
        check({tag, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_if.rd_data), 32'(exp));
    endtask

    task automatic read_end(input string tag);
        rd_if.rd_en = 1'b0;
        step();
        check(tag, 32'(rd_if.rd_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] e;
        rst = 1'b0; arm = 1'b0; abort = 1'b0; div = '0; trig_level = '0;
        post_count = '0; wave_in = '0; rd_if.rd_en = 1'b0; rd_if.rd_addr = '0;
        ramp_on = 1'b0; ramp_val = '0; hold = 1; hold_cnt = 0;

        #12;
        check("rst_armed", 32'(armed), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_trig_index", 32'(trig_index), 0);
        check("rst_rd_valid", 32'(rd_if.rd_valid), 0);
        check("rst_rd_data", 32'(rd_if.rd_data), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: reset while in POST, then re-arm
        div = 16'd0; trig_level = 8'h80; post_count = 4'd14;
        ramp_on = 1'b1; ramp_val = 8'h00; hold = 1; hold_cnt = 0; wave_in = 8'h00;
        pulse_arm();
        n = 0;
        while (!(busy && !armed) && n < 60) begin
            step();
            n++;
        end
        check("t1_in_post", 32'({busy, armed, done}), 32'b100);
        check("t1_trig_index", 32'(trig_index), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t1_async_rst", 32'({busy, armed, done}), 32'b000);
        check("t1_rst_trig_index", 32'(trig_index), 32'd0);
        #2 rst = 1'b1;
        pulse_arm();
        check("t1_rearm", 32'({busy, armed, done}), 32'b110);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t1_abort", 32'({busy, armed, done}), 32'b000);

        // Test 2: div=0 ramp, trigger on 0x70->0x80
        post_count = 4'd4;
        pulse_arm();
        wait_done("t2_done", 100);
        check("t2_trig_index", 32'(trig_index), 32'd11);
        check("t2_idle_valid", 32'(rd_if.rd_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            e = 8'(128 + 16 * (i - 11));
            read_chk($sformatf("t2_rd%0d", i), i, e);
        end
        read_end("t2_rd_end");

        // Test 3: div=3 with the ramp held 4 clocks per step
        div = 16'd3; hold = 4; hold_cnt = 0;
        pulse_arm();
        wait_done("t3_done", 400);
        check("t3_trig_index", 32'(trig_index), 32'd11);
        for (int i = 0; i < 16; i++) begin
            e = 8'(128 + 16 * (i - 11));
            read_chk($sformatf("t3_rd%0d", i), i, e);
        end
        read_end("t3_rd_end");

        // Test 4: early crossing ignored until 11 samples precede it
        ramp_on = 1'b0; div = 16'd0; post_count = 4'd4;
        pulse_arm();
        check("t4_armed", 32'({busy, armed, done}), 32'b110);
        feed(8'h10); feed(8'h20); feed(8'h90);
        check("t4_early_ignored", 32'({busy, armed, done}), 32'b110);
        for (int i = 0; i < 8; i++) feed(8'h00);
        feed(8'hA0);
        check("t4_trig_post", 32'({busy, armed, done}), 32'b100);
        feed(8'hB1); feed(8'hB2); feed(8'hB3);
        check("t4_not_done", 32'(done), 32'd0);
        feed(8'hB4);
        check("t4_done", 32'(done), 32'd1);
        read_chk("t4_rd0", 0, 8'h10);
        read_chk("t4_rd2", 2, 8'h90);
        read_chk("t4_rd11", 11, 8'hA0);
        read_chk("t4_rd15", 15, 8'hB4);
        read_end("t4_rd_end");

        // Test 5a: post_count=0 triggers straight to DONE, needs 15 prior samples
        post_count = 4'd0;
        pulse_arm();
        for (int i = 0; i < 14; i++) feed(8'h00);
        feed(8'h80);
        check("t5a_fill14_ignored", 32'({busy, armed, done}), 32'b110);
        feed(8'h00);
        feed(8'h80);
        check("t5a_done", 32'({busy, armed, done}), 32'b001);
        check("t5a_trig_index", 32'(trig_index), 32'd15);
        read_chk("t5a_rd15", 15, 8'h80);
        read_chk("t5a_rd14", 14, 8'h00);
        read_chk("t5a_rd13", 13, 8'h80);
        read_chk("t5a_rd0", 0, 8'h00);
        read_end("t5a_rd_end");

        // Test 5b: post_count=15 accepts the first valid crossing
        post_count = 4'd15;
        pulse_arm();
        check("t5b_done_dropped", 32'({busy, armed, done}), 32'b110);
        feed(8'h00);
        feed(8'h80);
        check("t5b_trig_post", 32'({busy, armed, done}), 32'b100);
        check("t5b_trig_index", 32'(trig_index), 32'd0);
        for (int v = 1; v < 15; v++) feed(8'(v));
        check("t5b_not_done", 32'(done), 32'd0);
        feed(8'h0F);
        check("t5b_done", 32'(done), 32'd1);
        read_chk("t5b_rd0", 0, 8'h80);
        read_chk("t5b_rd1", 1, 8'h01);
        read_chk("t5b_rd15", 15, 8'h0F);
        read_end("t5b_rd_end");

        // Test 6: abort beats arm, held-high input never triggers, no reads while armed
        post_count = 4'd4;
        pulse_arm();
        check("t6_armed", 32'(armed), 32'd1);
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        check("t6_abort_wins", 32'({busy, armed, done}), 32'b000);
        pulse_arm();
        wave_in = 8'hFF;
        for (int i = 0; i < 40; i++) step();
        check("t6_no_trigger", 32'({busy, armed, done}), 32'b110);
        rd_if.rd_en = 1'b1; rd_if.rd_addr = 4'd3;
        step();
        check("t6_rd_valid", 32'(rd_if.rd_valid), 32'd0);
        check("t6_rd_data_hold", 32'(rd_if.rd_data), 32'h0F);
        rd_if.rd_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
